// File: rtl/spi_wishbone_burst_bridge.sv
// SPI mode-0 slave to Wishbone master bridge with auto-incrementing
// burst writes, prefetching burst reads, sticky write errors and timeout.
module spi_wishbone_burst_bridge #(
    parameter int ADDR_WIDTH     = 23,
    parameter int DATA_BYTES     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    spi_sck,
    input  logic                    spi_ss_n,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [8*DATA_BYTES-1:0] dat_o,
    output logic [DATA_BYTES-1:0]   sel_o,
    input  logic [8*DATA_BYTES-1:0] dat_i,
    input  logic                    ack_i,
    input  logic                    err_i,
    input  logic                    rty_i
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = 6;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_HEADER,
        S_WRITE,
        S_READ
    } state_t;

    logic [1:0]            r_sck_s;
    logic [1:0]            r_ss_s;
    logic [1:0]            r_mosi_s;
    logic                  r_sck_q;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_hdr;
    logic [DW-2:0]         r_wsh;
    logic [DW:0]           r_rsh;
    logic [CW-1:0]         r_rcnt;
    logic [DW:0]           r_hold;
    logic                  r_hold_valid;
    logic [TW-1:0]         r_tmo;
    logic                  r_sticky;
    logic                  r_miso;
    logic                  r_cyc;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DW-1:0]         r_dat;

    logic                  w_edge;
    logic                  w_mosi;
    logic                  w_abort;
    logic [ADDR_WIDTH:0]   w_hdr_next;
    logic [DW-1:0]         w_word;
    logic                  w_tmo_hit;
    logic                  w_term;
    logic                  w_fail;

    assign w_edge     = r_sck_s[1] & ~r_sck_q;
    assign w_mosi     = r_mosi_s[1];
    assign w_abort    = r_ss_s[1];
    assign w_hdr_next = {r_hdr, w_mosi};
    assign w_word     = {r_wsh, w_mosi};
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_term     = r_cyc & (ack_i | err_i | rty_i | w_tmo_hit);
    assign w_fail     = ~ack_i;

    assign spi_miso = r_miso;
    assign cyc_o    = r_cyc;
    assign stb_o    = r_cyc;
    assign we_o     = r_we;
    assign adr_o    = r_adr;
    assign dat_o    = r_dat;
    assign sel_o    = '1;

    // Two-flop synchronisers for the SPI pins plus previous SCK for edge detect.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sck_s  <= '0;
            r_ss_s   <= 2'b11;
            r_mosi_s <= '0;
            r_sck_q  <= 1'b0;
        end else begin
            r_sck_s  <= {r_sck_s[0], spi_sck};
            r_ss_s   <= {r_ss_s[0], spi_ss_n};
            r_mosi_s <= {r_mosi_s[0], spi_mosi};
            r_sck_q  <= r_sck_s[1];
        end
    end

    // Frame FSM: header decode, write/read bursts, Wishbone cycle control.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || w_abort) begin
            r_state      <= S_HEADER;
            r_cnt        <= '0;
            r_hdr        <= '0;
            r_wsh        <= '0;
            r_rsh        <= '0;
            r_rcnt       <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_tmo        <= '0;
            r_sticky     <= 1'b0;
            r_miso       <= 1'b0;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_dat        <= '0;
        end else begin
            if (r_cyc) begin
                if (w_term) begin
                    r_cyc <= 1'b0;
                    r_adr <= r_adr + 1'b1;
                    if (r_we) begin
                        if (w_fail) r_sticky <= 1'b1;
                    end else begin
                        r_hold       <= w_fail ? {1'b1, {DW{1'b0}}}
                                               : {1'b0, dat_i};
                        r_hold_valid <= 1'b1;
                    end
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
            if (w_edge) begin
                case (r_state)
                    S_HEADER: begin
                        r_hdr <= w_hdr_next[ADDR_WIDTH-1:0];
                        if (r_cnt == CW'(ADDR_WIDTH)) begin
                            r_cnt <= '0;
                            r_we  <= w_hdr_next[ADDR_WIDTH];
                            r_adr <= w_hdr_next[ADDR_WIDTH-1:0];
                            if (w_hdr_next[ADDR_WIDTH]) begin
                                r_state <= S_WRITE;
                            end else begin
                                r_state <= S_READ;
                                r_cyc   <= 1'b1;
                                r_tmo   <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_WRITE: begin
                        r_miso <= r_sticky;
                        r_wsh  <= w_word[DW-2:0];
                        if (r_cnt == CW'(DW - 1)) begin
                            r_cnt <= '0;
                            if (!r_cyc) begin
                                r_dat <= w_word;
                                r_cyc <= 1'b1;
                                r_tmo <= '0;
                            end else begin
                                r_sticky <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_READ: begin
                        if (r_rcnt == '0) begin
                            if (r_hold_valid) begin
                                r_miso       <= 1'b1;
                                r_rsh        <= r_hold;
                                r_rcnt       <= CW'(DW + 1);
                                r_hold_valid <= 1'b0;
                                r_cyc        <= 1'b1;
                                r_tmo        <= '0;
                            end else begin
                                r_miso <= 1'b0;
                            end
                        end else begin
                            r_miso <= r_rsh[DW];
                            r_rsh  <= {r_rsh[DW-1:0], 1'b0};
                            r_rcnt <= r_rcnt - 1'b1;
                        end
                    end
                    default: r_state <= S_HEADER;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_wishbone_burst_bridge.sv
// Self-checking bench for spi_wishbone_burst_bridge: vector table,
// randomized frames against a word-level model, and corner sequences.
module tb_spi_wishbone_burst_bridge;

    localparam int HALF = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        spi_sck;
    logic        spi_ss_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [22:0] adr_o;
    logic [7:0]  dat_o;
    logic [0:0]  sel_o;
    logic [7:0]  dat_i;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    always #5 clk_i = ~clk_i;

    spi_wishbone_burst_bridge #(
        .ADDR_WIDTH(23),
        .DATA_BYTES(1),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .spi_sck(spi_sck),
        .spi_ss_n(spi_ss_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .cyc_o(cyc_o),
        .stb_o(stb_o),
        .we_o(we_o),
        .adr_o(adr_o),
        .dat_o(dat_o),
        .sel_o(sel_o),
        .dat_i(dat_i),
        .ack_i(ack_i),
        .err_i(err_i),
        .rty_i(rty_i)
    );

    typedef struct {
        bit          we;
        logic [22:0] adr;
        logic [7:0]  dat;
    } wb_rec_t;

    typedef struct {
        bit          we;
        logic [22:0] adr;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          mode;
        int          dly;
        logic [19:0] exp_bits;
        logic [22:0] exp_a0;
        logic [22:0] exp_a1;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    // slave mode: 0 none, 1 ack, 2 err, 3 rty, 4 ack+err together
    int slv_mode = 1;
    int slv_dly  = 2;
    logic [7:0] mem [logic [22:0]];
    wb_rec_t wlog[$];
    wb_rec_t rlog[$];

    function automatic logic [7:0] rd_data(input logic [22:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic sck_edge(input logic mosi, output logic miso_s);
        spi_mosi = mosi;
        tick(HALF);
        spi_sck = 1'b1;
        tick(HALF);
        miso_s  = spi_miso;
        spi_sck = 1'b0;
    endtask

    task automatic frame_start();
        spi_ss_n = 1'b0;
        tick(8);
    endtask

    task automatic frame_end();
        tick(8);
        spi_ss_n = 1'b1;
        tick(8);
    endtask

    task automatic hdr_bits(input logic [23:0] h, input int nb);
        logic m;
        for (int i = 23; i > 23 - nb; i--) sck_edge(h[i], m);
    endtask

    task automatic write_words(input logic [7:0] d [4], input int n,
                               output logic [63:0] bits);
        logic m;
        bits = '0;
        for (int k = 0; k < n; k++)
            for (int b = 7; b >= 0; b--) begin
                sck_edge(d[k][b], m);
                bits = {bits[62:0], m};
            end
    endtask

    task automatic read_edges(input int n, output logic [63:0] bits);
        logic m;
        bits = '0;
        for (int k = 0; k < n; k++) begin
            sck_edge(1'b0, m);
            bits = {bits[62:0], m};
        end
    endtask

    // Wishbone slave: terminates after slv_dly cycles and logs each transfer.
    initial begin
        int cnt;
        cnt   = 0;
        ack_i = 1'b0;
        err_i = 1'b0;
        rty_i = 1'b0;
        dat_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (ack_i || err_i || rty_i) begin
                ack_i = 1'b0;
                err_i = 1'b0;
                rty_i = 1'b0;
                dat_i = '0;
                cnt   = 0;
            end else if (cyc_o) begin
                cnt++;
                if (slv_mode != 0 && cnt >= slv_dly) begin
                    wb_rec_t r;
                    r.we  = we_o;
                    r.adr = adr_o;
                    r.dat = we_o ? dat_o : rd_data(adr_o);
                    case (slv_mode)
                        1: begin ack_i = 1'b1; dat_i = r.dat; end
                        2: begin err_i = 1'b1; dat_i = 8'hEE; end
                        3: begin rty_i = 1'b1; dat_i = 8'hEE; end
                        default: begin
                            ack_i = 1'b1;
                            err_i = 1'b1;
                            dat_i = r.dat;
                        end
                    endcase
                    if (we_o) wlog.push_back(r);
                    else rlog.push_back(r);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vt [7];
        logic [63:0] bits;
        logic [63:0] expb;
        logic [7:0]  d [4];
        logic [22:0] a;
        logic [22:0] adr;
        int          n;
        int          k;
        bit          we;
        logic        e;

        vt[0] = '{1'b1, 23'h000010, 8'hA5, 8'h3C, 1, 2, 20'h0,
                  23'h000010, 23'h000011};
        vt[1] = '{1'b1, 23'h7FFFFF, 8'hFF, 8'h00, 1, 5, 20'h0,
                  23'h7FFFFF, 23'h000000};
        vt[2] = '{1'b0, 23'h7FFFFF, 8'h11, 8'h22, 1, 3, 20'h84622,
                  23'h7FFFFF, 23'h000000};
        vt[3] = '{1'b0, 23'h000100, 8'h77, 8'h88, 2, 2, 20'hC0300,
                  23'h000100, 23'h000101};
        vt[4] = '{1'b0, 23'h123456, 8'hA5, 8'h5A, 1, 1, 20'hA965A,
                  23'h123456, 23'h123457};
        vt[5] = '{1'b0, 23'h000200, 8'h66, 8'h99, 3, 2, 20'hC0300,
                  23'h000200, 23'h000201};
        vt[6] = '{1'b0, 23'h000400, 8'h3C, 8'hC3, 4, 2, 20'h8F2C3,
                  23'h000400, 23'h000401};

        // reset with SCK toggling, then release with SS_n high
        rst_ni   = 1'b0;
        spi_ss_n = 1'b0;
        spi_mosi = 1'b1;
        spi_sck  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(4);
            spi_sck = ~spi_sck;
        end
        check("reset_outputs",
              {cyc_o, stb_o, we_o, adr_o, dat_o, spi_miso}, 0);
        check("reset_sel", sel_o, 1);
        spi_sck  = 1'b0;
        spi_ss_n = 1'b1;
        tick(2);
        rst_ni = 1'b1;
        tick(10);
        check("post_reset_outputs",
              {cyc_o, stb_o, we_o, adr_o, dat_o, spi_miso}, 0);

        // vector table
        for (int i = 0; i < 7; i++) begin
            slv_mode = vt[i].mode;
            slv_dly  = vt[i].dly;
            wlog.delete();
            rlog.delete();
            a = vt[i].adr + 23'd1;
            if (!vt[i].we) begin
                mem[vt[i].adr] = vt[i].b0;
                mem[a]         = vt[i].b1;
            end
            frame_start();
            hdr_bits({vt[i].we, vt[i].adr}, 24);
            if (vt[i].we) begin
                d[0] = vt[i].b0;
                d[1] = vt[i].b1;
                write_words(d, 2, bits);
            end else begin
                read_edges(20, bits);
            end
            frame_end();
            check($sformatf("vec%0d_miso", i), bits, 64'(vt[i].exp_bits));
            if (vt[i].we) begin
                check($sformatf("vec%0d_nwrites", i), wlog.size(), 2);
                if (wlog.size() >= 2) begin
                    check($sformatf("vec%0d_w0", i), {wlog[0].adr, wlog[0].dat},
                          {vt[i].exp_a0, vt[i].b0});
                    check($sformatf("vec%0d_w1", i), {wlog[1].adr, wlog[1].dat},
                          {vt[i].exp_a1, vt[i].b1});
                end
            end else begin
                check($sformatf("vec%0d_nreads", i), rlog.size() >= 2, 1);
                if (rlog.size() >= 2) begin
                    check($sformatf("vec%0d_r0", i), rlog[0].adr, vt[i].exp_a0);
                    check($sformatf("vec%0d_r1", i), rlog[1].adr, vt[i].exp_a1);
                end
            end
        end

        // randomized frames against a word-level model
        for (int it = 0; it < 8; it++) begin
            we  = 1'($urandom_range(0, 1));
            adr = 23'($urandom);
            if ($urandom_range(0, 2) == 0)
                adr = 23'h7FFFFF - 23'($urandom_range(0, 2));
            n        = int'($urandom_range(1, 3));
            slv_dly  = int'($urandom_range(1, 8));
            slv_mode = we ? 1 : (($urandom_range(0, 3) == 0) ? 2 : 1);
            wlog.delete();
            rlog.delete();
            expb = '0;
            for (k = 0; k < n; k++) begin
                a    = adr + 23'(k);
                d[k] = 8'($urandom);
                if (!we) begin
                    mem[a] = d[k];
                    e      = (slv_mode != 1);
                    expb   = (expb << 10) | 64'({1'b1, e, e ? 8'h00 : d[k]});
                end
            end
            frame_start();
            hdr_bits({we, adr}, 24);
            if (we) write_words(d, n, bits);
            else read_edges(10 * n, bits);
            frame_end();
            check($sformatf("rnd%0d_miso", it), bits, expb);
            if (we) begin
                check($sformatf("rnd%0d_nwrites", it), wlog.size(), n);
                for (k = 0; k < n && k < wlog.size(); k++)
                    check($sformatf("rnd%0d_w%0d", it, k),
                          {wlog[k].adr, wlog[k].dat},
                          {adr + 23'(k), d[k]});
            end
        end

        // slow slave: poll zeros precede the marker
        slv_mode = 1;
        slv_dly  = 40;
        mem[23'h000500] = 8'h99;
        frame_start();
        hdr_bits({1'b0, 23'h000500}, 24);
        read_edges(14, bits);
        frame_end();
        n = 0;
        while (n < 14 && bits[13 - n] == 1'b0) n++;
        check("slow_poll_zeros", (n >= 1 && n <= 3), 1);
        if (n <= 4)
            check("slow_word", (bits >> (4 - n)) & 64'h3FF, 64'h299);

        // timeout: no termination, cycle held exactly 255 clocks
        slv_mode = 0;
        frame_start();
        hdr_bits({1'b0, 23'h000300}, 23);
        spi_mosi = 1'b0;
        tick(HALF);
        spi_sck = 1'b1;
        k = 0;
        while (!cyc_o && k < 40) begin
            tick(1);
            k++;
        end
        check("timeout_open", {cyc_o, stb_o}, 2'b11);
        n = 0;
        while (cyc_o && n < 400) begin
            n++;
            tick(1);
        end
        check("timeout_len", n, 255);
        spi_sck = 1'b0;
        read_edges(10, bits);
        frame_end();
        check("timeout_word", bits, 64'h300);

        // write overlap: word completing during an open cycle is dropped
        slv_mode = 1;
        slv_dly  = 200;
        wlog.delete();
        frame_start();
        hdr_bits({1'b1, 23'h000600}, 24);
        d[0] = 8'h11;
        d[1] = 8'h22;
        d[2] = 8'h33;
        write_words(d, 3, bits);
        tick(230);
        frame_end();
        check("overlap_miso", bits, 64'h0000FF);
        check("overlap_nwrites", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            check("overlap_w0", {wlog[0].adr, wlog[0].dat}, {23'h000600, 8'h11});
            check("overlap_w1", {wlog[1].adr, wlog[1].dat}, {23'h000601, 8'h33});
        end

        // next frame after the error starts with sticky cleared
        slv_dly = 2;
        wlog.delete();
        frame_start();
        hdr_bits({1'b1, 23'h000700}, 24);
        d[0] = 8'h5A;
        write_words(d, 1, bits);
        frame_end();
        check("clean_miso", bits, 0);
        check("clean_nwrites", wlog.size(), 1);
        if (wlog.size() >= 1)
            check("clean_w0", {wlog[0].adr, wlog[0].dat}, {23'h000700, 8'h5A});

        // abort with an open read cycle
        slv_mode = 0;
        frame_start();
        hdr_bits({1'b0, 23'h000040}, 24);
        check("abort_open", cyc_o, 1);
        spi_ss_n = 1'b1;
        n = 0;
        while (cyc_o && n < 10) begin
            tick(1);
            n++;
        end
        check("abort_drop", (n <= 3 && !cyc_o), 1);
        check("abort_idle",
              {cyc_o, stb_o, we_o, adr_o, dat_o, spi_miso}, 0);
        tick(8);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_wishbone_burst_bridge.md
# spi_wishbone_burst_bridge

SPI-slave-to-Wishbone-master bridge with parametrised address and data width, auto-incrementing burst reads and writes, read prefetch, per-word error reporting and a bus timeout. It connects the chip's SPI pins to the internal Wishbone fabric. Host tools use it to stream blocks to and from SRAM and registers in one SS_n frame instead of one 32-bit transaction per byte.

## Interface
- ADDR_WIDTH, 23, Wishbone word-address width; 1..30.
- DATA_BYTES, 1, bytes per data word; DW = 8*DATA_BYTES; 1..4.
- TIMEOUT_CYCLES, 255, clk_i cycles a Wishbone cycle may stay open before it is abandoned; ≥ 2.
- clk_i  in  1  sole clock.
- rst_ni  in  1  synchronous active-low reset.
- spi_sck, spi_ss_n, spi_mosi  in  1 each  asynchronous SPI pins, mode 0, MSB first.
- spi_miso  out  1  registered serial output.
- cyc_o, stb_o  out  1  stb_o == cyc_o at all times.
- we_o  out  1  write enable.
- adr_o  out  ADDR_WIDTH  word address.
- dat_o  out  DW  write data.
- sel_o  out  DATA_BYTES  always all ones.
- dat_i  in  DW  read data.
- ack_i, err_i, rty_i  in  1 each  cycle terminations; any one ends the cycle.

## Operation
- Sync: spi_sck, spi_ss_n and spi_mosi each pass through a 2-flop synchroniser. "Edge" means a rising edge of synchronised SCK, detected against a registered previous value.
- Abort: rst_ni low, or synchronised SS_n high, forces all state to idle on the next clock.
  - Idle values: cyc_o=0, stb_o=0, we_o=0, adr_o=0, dat_o=0, spi_miso=0, sticky_err=0, all counters and valid flags 0.
  - An in-flight Wishbone cycle is dropped without waiting for termination.
- States:
  - HEADER: shift 1+ADDR_WIDTH MOSI bits (we, then address MSB first). On the last bit, latch we_o and adr_o, then go to WRITE or READ.
  - WRITE: shift DW MOSI bits per word.
    - On the last bit of a word: if no cycle is open, load dat_o, raise cyc_o with we_o=1, and advance the address counter.
    - If a cycle is still open at that point: drop the word and set sticky_err.
    - err_i, rty_i or timeout also set sticky_err.
    - MISO outputs sticky_err on every edge.
  - READ: on entry, immediately open a read cycle at the latched address. On termination, capture {err, dat_i} into the holding register, set hold_valid, close the cycle, increment adr_o.
  - READ response frame: per edge, while the shifter is idle:
    - hold_valid=0: MISO=0 (poll bit).
    - hold_valid=1: MISO=1 (marker). Move the holding register into the shifter, clear hold_valid, and open the next read (prefetch) in the same clock.
    - The following edges shift out the err bit, then DW data bits MSB first. The shifter then returns to idle.
- err bit: 0 on ack_i. 1 on err_i, rty_i or timeout; data is then forced to 0.
- Timeout: a counter runs while cyc_o=1 and clears when a cycle opens. Reaching TIMEOUT_CYCLES closes the cycle as an error.
- Termination priority when asserted together: ack_i > err_i > rty_i; the data/err capture follows the winner.
- Address wraps modulo 2^ADDR_WIDTH.
- A termination input seen while cyc_o=0 is ignored.

## Timing
- Pin-to-action latency: 3 clk_i from a spi_sck rise to the shift or MISO update.
- spi_miso changes 3–4 clk_i after the SCK rise that advances it. The master samples it on the next SCK rise.
- SCK high and low phases must each be ≥ 4 clk_i. SS_n setup/hold to SCK must be ≥ 4 clk_i.
- cyc_o rises on the clock after the word-completing edge is detected. It falls on the clock after termination is sampled.
- Back-to-back write words are lossless if the slave terminates within DW*8 − 2 clk_i.
- Prefetch opens at the marker edge, so read throughput needs termination within (DW+1)*8 clk_i; otherwise poll zeros appear.

## Test plan
- Reset: hold rst_ni=0 with SCK toggling → all outputs 0. Release with SS_n high → outputs stay 0.
- Write burst (ADDR_WIDTH=23, DATA_BYTES=1): header we=1, adr=0x000010, then bytes 0xA5, 0x3C; slave acks after 2 clk → writes to 0x10=0xA5 and 0x11=0x3C; MISO stays 0.
- Read burst with prefetch: header we=0, adr=0x7FFFFF; slave returns 0x11, 0x22 with ack after 3 clk; clock 20 edges → MISO sequence 0…,1,0,00010001,1,0,00100010. Second read address is 0x000000 (wrap).
- Slow slave: ack delayed 40 clk on a read → MISO shows poll zeros until the holding register fills, then the marker and data.
- Error paths: err_i on a read → err bit 1, data 0x00. No termination → cyc_o drops after exactly 255 clk with err bit 1. In a write burst, a word completing while a cycle is open → word dropped and MISO=1 on the following edges.
- Abort: raise SS_n mid-cycle with cyc_o=1 → cyc_o=0 within 3 clk. The next frame starts cleanly in HEADER with sticky_err cleared.
